// File: rtl/instr_fetch_pkg.sv
// Shared constants and types for the instruction fetch stage: opcode field width,
// default HALT opcode and the RUN/HALTED state encoding.
package instr_fetch_pkg;

   localparam int unsigned OPCODE_BITS = 3;
   localparam logic [OPCODE_BITS-1:0] HALT_OPCODE_DEFAULT = 3'b111;

   typedef enum logic {
      StRun    = 1'b0,
      StHalted = 1'b1
   } state_e;

   // True when exactly one of the three fde strobes is asserted.
   function automatic logic strobe_one_hot(input logic f, input logic d, input logic e);
      return ({f, d, e} == 3'b100) || ({f, d, e} == 3'b010) || ({f, d, e} == 3'b001);
   endfunction

endpackage

// File: rtl/instr_fetch_pc_counter.sv
// Program counter register: synchronous reset, load, increment with wrap, or hold.
module instr_fetch_pc_counter #(
   parameter int unsigned            WIDTH     = 5,
   parameter logic [WIDTH-1:0]       RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             incr,
   input  logic [WIDTH-1:0] load_value,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= RESET_VAL;
      end else if (load) begin
         count <= load_value;
      end else if (incr) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the instruction register, RUN/HALTED state and strobe qualification.
// Define IFETCH_COUNT_EN to add the 16-bit `retired` decode counter output.
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter int unsigned            ADDRESS_BITS = 5,
   parameter int unsigned            DATA_BITS    = 8,
   parameter logic [OPCODE_BITS-1:0] HALT_OPCODE  = HALT_OPCODE_DEFAULT,
   parameter int unsigned            RESET_PC     = 0
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    enable,
   input  logic                    fetch,
   input  logic                    decode,
   input  logic                    execute,
   input  logic [DATA_BITS-1:0]    mem_data,
   input  logic                    jump,
   input  logic [ADDRESS_BITS-1:0] jump_addr,
   output logic [ADDRESS_BITS-1:0] pc,
   output logic [DATA_BITS-1:0]    ir,
   output logic [OPCODE_BITS-1:0]  opcode,
   output logic [ADDRESS_BITS-1:0] operand,
   output logic                    ir_valid,
`ifdef IFETCH_COUNT_EN
   output logic [15:0]             retired,
`endif
   output logic                    halted
);

   state_e state;
   logic   qualified;
   logic   do_decode;
   logic   do_execute;
   logic   is_halt;

   // HALTED ignores every strobe, so qualification folds the state in as well.
   assign qualified  = enable && strobe_one_hot(fetch, decode, execute) && (state == StRun);
   assign do_decode  = qualified && decode;
   assign do_execute = qualified && execute;
   assign is_halt    = (mem_data[DATA_BITS-1 -: OPCODE_BITS] == HALT_OPCODE);

   instr_fetch_pc_counter #(
      .WIDTH     (ADDRESS_BITS),
      .RESET_VAL (ADDRESS_BITS'(RESET_PC))
   ) u_pc_counter (
      .clk        (clk),
      .reset      (reset),
      .load       (do_execute && jump),
      .incr       (do_decode && !is_halt),
      .load_value (jump_addr),
      .count      (pc)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= StRun;
         ir       <= '0;
         ir_valid <= 1'b0;
      end else if (do_decode) begin
         ir       <= mem_data;
         ir_valid <= 1'b1;
         if (is_halt) begin
            state <= StHalted;
         end
      end
   end

`ifdef IFETCH_COUNT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         retired <= '0;
      end else if (do_decode) begin
         retired <= retired + 16'd1;
      end
   end
`endif

   assign halted  = (state == StHalted);
   assign opcode  = ir[DATA_BITS-1 -: OPCODE_BITS];
   assign operand = ir[ADDRESS_BITS-1:0];

endmodule
